// File: rtl/irq_exc_ctrl.sv
// rtl/irq_exc_ctrl.sv - interrupt/exception request arbiter for CP0 with in-service nesting stack
module irq_exc_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] irq_in,
  input  logic       mask_we,
  input  logic [2:0] mask_wdata,
  output logic [2:0] mask,
  input  logic       exc_undef,
  input  logic       exc_ovf,
  input  logic       exc_oor,
  input  logic       ack,
  input  logic       eret,
  output logic [2:0] cause,
  output logic [2:0] int_level,
  output logic [2:0] pending,
  output logic [1:0] cur_level,
  output logic       double_fault,
  output logic       eret_underflow
);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXC_REQ = 2'd1, INT_REQ = 2'd2} state_t;
  state_t state, state_n;

  logic [2:0]     sync_q [SYNC_STAGES];
  logic [2:0]     lvl_q, lvl_d, rise;
  logic [2:0]     exc_pend, exc_new, exc_code, best_level, eligible, ack_clr;
  logic [1:0]     stack_q [STACK_DEPTH];
  logic [SPW-1:0] sp_q, sp_mid;
  logic [IW-1:0]  top_idx;
  logic [1:0]     pop_val;
  logic           exc_active, ack_exc, ack_int, push, push_ok, pop_ok, underflow;

  // lvl_q/lvl_d add one stage past the synchronizer so edges land at N+SYNC_STAGES+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      lvl_q <= '0;
      lvl_d <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      lvl_q <= sync_q[SYNC_STAGES-1];
      lvl_d <= lvl_q;
    end
  end

  assign rise    = lvl_q & ~lvl_d;
  assign exc_new = {exc_oor, exc_ovf, exc_undef};

  always_comb begin
    eligible[0] = pending[0] & ~mask[0] & (cur_level < 2'd1) & ~exc_active;
    eligible[1] = pending[1] & ~mask[1] & (cur_level < 2'd2) & ~exc_active;
    eligible[2] = pending[2] & ~mask[2] & (cur_level < 2'd3) & ~exc_active;
    best_level  = eligible[2] ? 3'd3 : eligible[1] ? 3'd2 : eligible[0] ? 3'd1 : 3'd0;
    exc_code    = exc_pend[2] ? 3'b100 : exc_pend[1] ? 3'b010 : exc_pend[0] ? 3'b001 : 3'b000;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|exc_pend) state_n = EXC_REQ;
               else if (|eligible) state_n = INT_REQ;
      EXC_REQ: if (ack) state_n = IDLE;
      INT_REQ: if (ack || |exc_pend) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // An ERET in the same cycle as an ack pops the entry the ack just pushed
  assign ack_exc   = (state == EXC_REQ) && ack;
  assign ack_int   = (state == INT_REQ) && ack;
  assign push      = ack_exc || ack_int;
  assign push_ok   = push && (sp_q != SPW'(STACK_DEPTH));
  assign sp_mid    = sp_q + SPW'(push_ok);
  assign pop_ok    = eret && (sp_mid != '0);
  assign underflow = eret && (sp_mid == '0);
  assign top_idx   = sp_mid[IW-1:0] - IW'(1);
  assign pop_val   = push_ok ? cur_level : stack_q[top_idx];
  assign ack_clr   = {ack_int && (int_level == 3'd3),
                      ack_int && (int_level == 3'd2),
                      ack_int && (int_level == 3'd1)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask           <= 3'b111;
      cause          <= '0;
      int_level      <= '0;
      pending        <= '0;
      cur_level      <= '0;
      double_fault   <= 1'b0;
      eret_underflow <= 1'b0;
      exc_pend       <= '0;
      exc_active     <= 1'b0;
      sp_q           <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      if (mask_we) mask <= mask_wdata;
      pending        <= (pending & ~ack_clr) | rise;
      exc_pend       <= (exc_pend & ~(ack_exc ? cause : 3'b000)) | (exc_active ? 3'b000 : exc_new);
      eret_underflow <= underflow;
      if ((push && !push_ok) || (exc_active && |exc_new)) double_fault <= 1'b1;
      if (push_ok) stack_q[sp_q[IW-1:0]] <= cur_level;
      sp_q <= sp_mid - SPW'(pop_ok);
      if (ack_exc) begin
        cur_level  <= 2'd3;
        exc_active <= 1'b1;
      end else if (ack_int) begin
        cur_level  <= int_level[1:0];
      end
      if (pop_ok) begin
        cur_level  <= pop_val;
        exc_active <= 1'b0;
      end
      case (state)
        IDLE:    if (|exc_pend) cause <= exc_code;
                 else if (|eligible) int_level <= best_level;
        EXC_REQ: if (ack) cause <= '0;
        INT_REQ: if (ack || |exc_pend) int_level <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_exc_ctrl.sv
// tb/tb_irq_exc_ctrl.sv - scoreboard bench for irq_exc_ctrl with a transaction-level reference model
module tb_irq_exc_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic [2:0] irq_in = '0, mask_wdata = '0;
  logic       mask_we = 1'b0, exc_undef = 1'b0, exc_ovf = 1'b0, exc_oor = 1'b0, ack = 1'b0, eret = 1'b0;
  logic [2:0] mask, cause, int_level, pending;
  logic [1:0] cur_level;
  logic       double_fault, eret_underflow;

  irq_exc_ctrl #(.SYNC_STAGES(2), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata), .mask(mask),
    .exc_undef(exc_undef), .exc_ovf(exc_ovf), .exc_oor(exc_oor), .ack(ack), .eret(eret),
    .cause(cause), .int_level(int_level), .pending(pending), .cur_level(cur_level),
    .double_fault(double_fault), .eret_underflow(eret_underflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [5:0] exp_q[$];
  int pushed = 0, seen = 0, skipped = 0;

  // Reference model: request codes are {cause, int_level}
  logic [2:0] m_pend, m_mask, m_exc;
  int         m_cur;
  bit         m_exc_active, m_df;
  int         m_stack[$];
  logic [5:0] m_held;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  logic [5:0] mon_prev = '0, mon_now;
  always @(negedge clk) begin
    mon_now = {cause, int_level};
    if (!rst && mon_now != 6'd0 && mon_prev == 6'd0) begin
      if (exp_q.size() == 0) chk("unexpected_req", int'(mon_now), 0);
      else begin
        chk("req", int'(mon_now), int'(exp_q.pop_front()));
        seen++;
      end
    end
    mon_prev = mon_now;
  end

  task automatic m_reset();
    m_pend = '0; m_mask = 3'b111; m_exc = '0; m_cur = 0;
    m_exc_active = 0; m_df = 0; m_stack.delete(); m_held = '0;
  endtask

  function automatic logic [5:0] m_next_req();
    if (m_exc[2]) return {3'b100, 3'd0};
    if (m_exc[1]) return {3'b010, 3'd0};
    if (m_exc[0]) return {3'b001, 3'd0};
    if (m_exc_active) return '0;
    for (int k = 3; k >= 1; k--)
      if (m_pend[k-1] && !m_mask[k-1] && k > m_cur) return {3'b000, 3'(k)};
    return '0;
  endfunction

  task automatic expect_next();
    if (m_held == '0) begin
      m_held = m_next_req();
      if (m_held != '0) begin
        exp_q.push_back(m_held);
        pushed++;
      end
    end
  endtask

  task automatic m_push(input int v);
    if (m_stack.size() >= DEPTH) m_df = 1;
    else m_stack.push_back(v);
  endtask

  task automatic wait_seen();
    int t = 0;
    while (seen + skipped < pushed && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("req_presented", seen + skipped, pushed);
    if (seen + skipped < pushed) begin
      skipped = pushed - seen;
      exp_q.delete();
    end
  endtask

  task automatic do_irq(input logic [2:0] bits);
    @(negedge clk); irq_in = bits;
    m_pend |= bits;
    expect_next();
    @(negedge clk); irq_in = '0;
  endtask

  task automatic do_exc(input logic [2:0] bits);
    @(negedge clk); {exc_oor, exc_ovf, exc_undef} = bits;
    if (m_exc_active) m_df = 1;
    else m_exc |= bits;
    if (m_held[2:0] != 3'd0 && m_exc != 3'd0) m_held = '0;
    expect_next();
    @(negedge clk); {exc_oor, exc_ovf, exc_undef} = 3'b000;
  endtask

  task automatic do_mask(input logic [2:0] v);
    @(negedge clk); mask_we = 1'b1; mask_wdata = v;
    m_mask = v;
    expect_next();
    @(negedge clk); mask_we = 1'b0;
  endtask

  task automatic do_ack();
    logic [2:0] lvl;
    wait_seen();
    @(negedge clk); ack = 1'b1;
    if (m_held[5:3] != 3'd0) begin
      m_exc &= ~m_held[5:3];
      m_push(m_cur);
      m_cur = 3;
      m_exc_active = 1;
    end else if (m_held[2:0] != 3'd0) begin
      lvl = m_held[2:0];
      m_pend[lvl-1] = 1'b0;
      m_push(m_cur);
      m_cur = int'(lvl);
    end
    m_held = '0;
    expect_next();
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic do_eret();
    bit exp_uf;
    @(negedge clk); eret = 1'b1;
    exp_uf = (m_stack.size() == 0);
    if (!exp_uf) begin
      m_cur = m_stack.pop_back();
      m_exc_active = 0;
    end
    expect_next();
    @(negedge clk); eret = 1'b0;
    chk("eret_underflow", int'(eret_underflow), int'(exp_uf));
    if (exp_uf) begin
      @(negedge clk);
      chk("eret_underflow_1cyc", int'(eret_underflow), 0);
    end
  endtask

  task automatic state_check(input string tag);
    chk({tag, "_cur_level"}, int'(cur_level), m_cur);
    chk({tag, "_pending"}, int'(pending), int'(m_pend));
    chk({tag, "_mask"}, int'(mask), int'(m_mask));
    chk({tag, "_double_fault"}, int'(double_fault), int'(m_df));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_mask", int'(mask), 7);
    chk("rst_cause", int'(cause), 0);
    chk("rst_int_level", int'(int_level), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_cur_level", int'(cur_level), 0);
    chk("rst_double_fault", int'(double_fault), 0);
    chk("rst_eret_underflow", int'(eret_underflow), 0);
    rst = 1'b0;

    // masked level 3 latches but is not presented until unmasked
    do_irq(3'b100);
    repeat (8) @(negedge clk);
    chk("masked_pending", int'(pending), 4);
    chk("masked_quiet", int'({cause, int_level}), 0);
    do_mask(3'b000);
    do_ack();
    chk("mask_ack_cur", int'(cur_level), 3);
    do_eret();
    do_eret();
    state_check("mask_test");

    // single interrupt latency and hold
    do_irq(3'b010);
    repeat (3) @(negedge clk);
    chk("lat_n3", int'(int_level), 0);
    @(negedge clk);
    chk("lat_n4", int'(int_level), 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_no_ack", int'(int_level), 2);
    end
    do_ack();
    chk("single_cur", int'(cur_level), 2);
    chk("single_pending", int'(pending), 0);

    // nesting: level 3 preempts level 2, level 1 waits
    do_irq(3'b101);
    repeat (8) @(negedge clk);
    do_ack();
    chk("nest_cur3", int'(cur_level), 3);
    do_eret();
    chk("nest_cur2", int'(cur_level), 2);
    chk("nest_pend1", int'(pending), 1);
    do_eret();
    repeat (4) @(negedge clk);
    do_ack();
    do_eret();
    state_check("nest");

    // simultaneous exceptions, then a discarded nested exception
    do_exc(3'b011);
    repeat (3) @(negedge clk);
    do_ack();
    do_ack();
    do_exc(3'b100);
    repeat (4) @(negedge clk);
    chk("dbl_fault", int'(double_fault), 1);
    chk("dbl_quiet", int'({cause, int_level}), 0);
    do_eret();
    do_eret();
    state_check("exc");

    // preemption of a held interrupt by an exception
    do_irq(3'b001);
    repeat (6) @(negedge clk);
    wait_seen();
    do_exc(3'b100);
    repeat (4) @(negedge clk);
    chk("preempt_pend0", int'(pending[0]), 1);
    do_ack();
    do_eret();
    repeat (4) @(negedge clk);
    wait_seen();

    // asynchronous reset in the middle of a held request
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_int_level", int'(int_level), 0);
    chk("midrst_cause", int'(cause), 0);
    chk("midrst_pending", int'(pending), 0);
    chk("midrst_cur", int'(cur_level), 0);
    chk("midrst_mask", int'(mask), 7);
    m_reset();
    @(negedge clk); rst = 1'b0;

    for (int it = 0; it < 150; it++) begin
      int sel, g;
      sel = $urandom_range(0, 99);
      if (sel < 35)      do_irq(3'($urandom_range(1, 7)));
      else if (sel < 55) do_exc(3'($urandom_range(1, 7)));
      else if (sel < 70) do_mask(($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7)));
      else               do_eret();
      repeat (8) @(negedge clk);
      g = 0;
      while (m_held != '0 && g < 10) begin
        do_ack();
        g++;
      end
      repeat (2) @(negedge clk);
      chk("rand_quiet", int'({cause, int_level}), 0);
      state_check("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/irq_exc_ctrl.md
# irq_exc_ctrl

Interrupt and exception request controller that drives the coprocessor-0 request side of the pipelined CPU. It synchronizes and edge-detects three external interrupt lines, latches pipeline exception pulses, and arbitrates by priority. It presents a single held request (`cause` or `int_level`) to CP0 until CP0 acknowledges it. It also keeps the nesting stack of in-service levels, which is popped on ERET.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops on `irq_in`. Legal range is 2–3.
- `STACK_DEPTH`, default 4: entries in the in-service nesting stack.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `irq_in`, in, 3: raw external interrupt lines. Bit k requests level k+1; level 3 is the highest priority.
- `mask_we`, in, 1: write strobe for the mask register.
- `mask_wdata`, in, 3: new mask value. A 1 masks that level.
- `mask`, out, 3: current mask.
- `exc_undef`, in, 1: undefined-instruction pulse from ID.
- `exc_ovf`, in, 1: overflow pulse from EXE.
- `exc_oor`, in, 1: out-of-range pulse from MEM.
- `ack`, in, 1: acknowledge from CP0 (its clear/taken strobe).
- `eret`, in, 1: one-cycle pulse when CP0 executes ERET.
- `cause`, out, 3: exception request code: 1 = undefined, 2 = overflow, 4 = out-of-range, 0 = none.
- `int_level`, out, 3: interrupt request level 0–3. 0 means no request.
- `pending`, out, 3: latched, not-yet-serviced interrupt edges.
- `cur_level`, out, 2: level currently in service. 3 is also used while an exception handler runs.
- `double_fault`, out, 1: sticky flag, cleared only by reset.
- `eret_underflow`, out, 1: one-cycle pulse.

## Operation
- **Reset values:**
  - `mask` = 3'b111.
  - `cause`, `int_level`, `pending`, `cur_level`, `double_fault`, `eret_underflow` = 0.
  - Stack empty; `exc_active` = 0; state = IDLE.
- **Interrupt capture:**
  - `irq_in` passes through a `SYNC_STAGES` synchronizer. A rising edge on the synchronized bit sets `pending[k]`.
  - Pending is cleared only when that level is acknowledged.
  - If a new edge and an ack of the same level occur in the same cycle, pending remains set.
- **Exception capture:**
  - Exception pulses OR into a 3-bit `exc_pend` register. Multiple pulses may accumulate.
  - Priority is by oldest pipeline stage: out-of-range, then overflow, then undefined.
- **Interrupt eligibility:** level k is eligible iff `pending[k-1]` is set, `mask[k-1]` is clear, `k > cur_level`, and `exc_active` = 0.
- **State machine:**
  - **IDLE:**
    - If `exc_pend` is nonzero, load `cause` with the highest-priority code and go to EXC_REQ.
    - Otherwise, if any level is eligible, load `int_level` with the highest eligible level and go to INT_REQ.
  - **EXC_REQ:** `cause` is held. On `ack`:
    - Clear that `exc_pend` bit.
    - Push `cur_level` onto the stack, set `cur_level` = 3, set `exc_active` = 1.
    - Drive `cause` = 0 and return to IDLE.
  - **INT_REQ:** `int_level` is held.
    - On `ack`: clear `pending`, push `cur_level`, set `cur_level` = `int_level`, drive `int_level` = 0, go to IDLE.
    - If `exc_pend` becomes nonzero before the ack: withdraw (`int_level` = 0, pending untouched) and go to IDLE. The exception is then issued on the following cycle.
- **ERET:**
  - Pop the stack into `cur_level` and clear `exc_active`.
  - If the stack is empty: fire `eret_underflow` and leave state unchanged.
  - If `eret` and `ack` occur in the same cycle, the ack push happens first, then the pop. Net effect: the stack is unchanged and `cur_level` equals the popped entry.
- **Exceptions during an exception handler:** an exception raised while `exc_active` = 1 sets `double_fault`, is discarded, and is not presented.
- **Stack full:** a push with the stack full sets `double_fault`. The push is dropped, but the request is still completed.
- **Mask writes:**
  - A mask write takes effect for arbitration on the next cycle.
  - A request already presented is not withdrawn by masking.
- **Stray acks:** `ack` in IDLE is ignored.

## Timing
- All outputs are registered.
- An `irq_in` rise sampled at edge N sets `pending` after edge N+`SYNC_STAGES`+1. `int_level` is valid one edge later (N+4 with default parameters).
- An exception pulse sampled at edge N: `cause` is valid after edge N+1 when the block is IDLE.
- A request is held until `ack`; there is no timeout. `ack` at edge M gives output 0 and the `cur_level` update after edge M. A new request can appear after edge M+1 at the earliest.
- ERET at edge M: `cur_level` is updated after edge M. Newly eligible lower levels can be presented after edge M+1.
- Reset asserted mid-request clears everything immediately; pending edges are lost.

## Test plan
- **Single interrupt:** `mask` = 0; pulse `irq_in[1]` → `int_level` = 2 four cycles later. Hold without ack for 10 cycles → `int_level` stays 2. Ack → `cur_level` = 2, `pending` = 0.
- **Nesting:** in service at level 2, raise `irq_in[0]` and `irq_in[2]` → only level 3 is presented. Ack → `cur_level` = 3. ERET → `cur_level` = 2. Level 1 stays pending. Second ERET → `cur_level` = 0, then level 1 is presented.
- **Simultaneous exceptions:** pulse `exc_ovf` and `exc_undef` in the same cycle → `cause` = 2. Ack → `cause` = 0, then `cause` = 1 next. A further exception before ERET → `double_fault` = 1, no request.
- **Preemption:** with `int_level` = 1 held, pulse `exc_oor` → `int_level` drops to 0, then `cause` = 4. `pending[0]` is still 1.
- **Mask and underflow:** reset mask = 7; pulse `irq_in[2]` → no request and `pending` = 3'b100. Write mask 0 → `int_level` = 3. ERET with an empty stack → `eret_underflow` pulses for 1 cycle.
- **Reset mid-request:** assert `rst` during INT_REQ → all outputs return to their reset values in the same cycle.
